// File: rtl/pll_lock_reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// pll_lock_reset_sequencer_if
//   Groups the PLL-facing and system-facing signals of the PLL lock / reset
//   sequencer into one bundle.
//   master : environment side. Drives pll_lock and restart, observes the rest.
//   slave  : sequencer side. Observes pll_lock and restart, drives the rest.
// Signals
//   pll_lock    PLL LOCK, asynchronous to the sequencer clock
//   restart     one-cycle pulse that leaves the FAULT state
//   pll_resetb  active-low PLL reset
//   sys_reset   active-high reset for the 100 MHz domain
//   pll_ready   high while the sequencer is in RUN
//   fault       high while the sequencer is in FAULT
//   loss_count  saturating count of lock losses seen in RUN
// -----------------------------------------------------------------------------
interface pll_lock_reset_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             pll_lock;
    logic             restart;
    logic             pll_resetb;
    logic             sys_reset;
    logic             pll_ready;
    logic             fault;
    logic [CNT_W-1:0] loss_count;

    modport master (
        output pll_lock,
        output restart,
        input  pll_resetb,
        input  sys_reset,
        input  pll_ready,
        input  fault,
        input  loss_count
    );

    modport slave (
        input  pll_lock,
        input  restart,
        output pll_resetb,
        output sys_reset,
        output pll_ready,
        output fault,
        output loss_count
    );
endinterface

// File: rtl/pll_lock_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_reset_sequencer
//   Runs on the 12 MHz PLL reference clock. Pulses the PLL active-low reset,
//   qualifies LOCK and releases the 100 MHz system reset only after lock has
//   been stable. Re-sequences the PLL on loss of lock, counts lock losses and
//   latches FAULT after MAX_RETRIES consecutive lock timeouts.
// Ports
//   clk   in  12 MHz reference clock
//   rst   in  asynchronous active-high reset
//   bus   slave modport: pll_lock/restart in; pll_resetb, sys_reset,
//         pll_ready, fault, loss_count out (all outputs registered)
// -----------------------------------------------------------------------------
module pll_lock_reset_sequencer #(
    parameter int RST_CYCLES    = 12,
    parameter int LOCK_TIMEOUT  = 1200,
    parameter int STABLE_CYCLES = 120,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    pll_lock_reset_sequencer_if.slave   bus
);

    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int RW      = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0]    RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]    LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_LIMIT = RW'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] LOSS_MAX    = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [RW-1:0]    retries_r;
    logic [CNT_W-1:0] loss_r;
    logic             lock_meta_r;
    logic             lock_sync_r;
    logic             pll_resetb_r;
    logic             sys_reset_r;
    logic             pll_ready_r;
    logic             fault_r;

    // Output pattern {pll_resetb, sys_reset, pll_ready, fault} for a state.
    // Corrupt encodings look like PLL_RST so the PLL and system stay held.
    function automatic logic [3:0] decode_outputs(input state_t s);
        logic [3:0] o;
        case (s)
            ST_PLL_RST:   o = 4'b0100;
            ST_WAIT_LOCK: o = 4'b1100;
            ST_STABLE:    o = 4'b1100;
            ST_RUN:       o = 4'b1010;
            ST_FAULT:     o = 4'b0101;
            default:      o = 4'b0100;
        endcase
        return o;
    endfunction

    // Two-flop synchronizer bringing the asynchronous PLL LOCK into clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= bus.pll_lock;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Sequencer FSM; outputs follow the registered state one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_PLL_RST;
            cnt_r        <= '0;
            retries_r    <= '0;
            loss_r       <= '0;
            pll_resetb_r <= 1'b0;
            sys_reset_r  <= 1'b1;
            pll_ready_r  <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            {pll_resetb_r, sys_reset_r, pll_ready_r, fault_r} <= decode_outputs(state_r);
            case (state_r)
                ST_PLL_RST: begin
                    if (cnt_r == RST_LAST) begin
                        state_r <= ST_WAIT_LOCK;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is tested first so a lock arriving in the timeout
                    // cycle does not burn a retry.
                    if (lock_sync_r) begin
                        state_r <= ST_STABLE;
                        cnt_r   <= '0;
                    end else if (cnt_r == LOCK_LAST) begin
                        cnt_r     <= '0;
                        retries_r <= retries_r + RW'(1);
                        if ((retries_r + RW'(1)) == RETRY_LIMIT) begin
                            state_r <= ST_FAULT;
                        end else begin
                            state_r <= ST_PLL_RST;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_sync_r) begin
                        state_r <= ST_WAIT_LOCK;
                        cnt_r   <= '0;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_r   <= ST_RUN;
                        cnt_r     <= '0;
                        retries_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_sync_r) begin
                        state_r <= ST_PLL_RST;
                        cnt_r   <= '0;
                        if (loss_r != LOSS_MAX) begin
                            loss_r <= loss_r + CNT_W'(1);
                        end else begin
                            loss_r <= loss_r;
                        end
                    end else begin
                        cnt_r <= '0;
                    end
                end
                ST_FAULT: begin
                    // Lock is ignored here; only an explicit restart leaves.
                    if (bus.restart) begin
                        state_r   <= ST_PLL_RST;
                        cnt_r     <= '0;
                        retries_r <= '0;
                    end else begin
                        cnt_r <= '0;
                    end
                end
                default: begin
                    state_r <= ST_PLL_RST;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign bus.pll_resetb = pll_resetb_r;
    assign bus.sys_reset  = sys_reset_r;
    assign bus.pll_ready  = pll_ready_r;
    assign bus.fault      = fault_r;
    assign bus.loss_count = loss_r;

endmodule
